// File: rtl/regfile_2r1w_if.sv
// Register file access bus: write port from writeback, two read ports to operand fetch.
interface regfile_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;

  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output data_writeReg,
    output ctrl_readRegA,
    output ctrl_readRegB,
    input  data_readRegA,
    input  data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  data_writeReg,
    input  ctrl_readRegA,
    input  ctrl_readRegB,
    output data_readRegA,
    output data_readRegB
  );
endinterface

// File: rtl/regfile_2r1w.sv
// MIPS register file: 2 combinational reads, 1 synchronous write, r0 hard-wired to zero.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic           clk,
  input logic           clr,
  regfile_2r1w_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   row_en;

  // Row 0 is never enabled, so it holds its cleared value forever.
  always_comb begin
    row_en = '0;
    for (int i = 1; i < NREG; i++) begin
      if (bus.ctrl_writeEnable && (bus.ctrl_writeReg == ADDR_W'(i)))
        row_en[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (row_en[i])
          regs[i] <= bus.data_writeReg;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic bypass_a;
  logic bypass_b;

  // Forwarding lets decode see the value writeback is committing this cycle.
  always_comb begin
    bypass_a = bus.ctrl_writeEnable && !clr && (bus.ctrl_writeReg != '0) &&
               (bus.ctrl_writeReg == bus.ctrl_readRegA);
    bypass_b = bus.ctrl_writeEnable && !clr && (bus.ctrl_writeReg != '0) &&
               (bus.ctrl_writeReg == bus.ctrl_readRegB);
  end

  assign bus.data_readRegA = bypass_a ? bus.data_writeReg : regs[bus.ctrl_readRegA];
  assign bus.data_readRegB = bypass_b ? bus.data_writeReg : regs[bus.ctrl_readRegB];
`else
  assign bus.data_readRegA = regs[bus.ctrl_readRegA];
  assign bus.data_readRegB = regs[bus.ctrl_readRegB];
`endif
endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed table, corner sequences, random vs. array model.
module tb_regfile_2r1w;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_b;
  } vec_t;

  logic clk;
  logic clr;
  int   vectors;
  int   miscompares;
  logic [DATA_W-1:0] ref_regs [NREG];
  vec_t table_v [8];

  regfile_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf_if ();

  regfile_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected read: stored value, or the in-flight write data when forwarding applies.
  function automatic logic [DATA_W-1:0] predict(input logic [ADDR_W-1:0] addr);
    if (BYPASS && rf_if.ctrl_writeEnable && !clr && rf_if.ctrl_writeReg != 0 &&
        rf_if.ctrl_writeReg == addr)
      return rf_if.data_writeReg;
    return ref_regs[addr];
  endfunction

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput({name, "_A"}, rf_if.data_readRegA, predict(rf_if.ctrl_readRegA));
    checkOutput({name, "_B"}, rf_if.data_readRegB, predict(rf_if.ctrl_readRegB));
  endtask

  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra,
                               input logic [ADDR_W-1:0] rb, input logic c);
    @(negedge clk);
    rf_if.ctrl_writeEnable = we;
    rf_if.ctrl_writeReg    = wa;
    rf_if.data_writeReg    = wd;
    rf_if.ctrl_readRegA    = ra;
    rf_if.ctrl_readRegB    = rb;
    clr                    = c;
    #1;
    if (c) for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
  endtask

  task automatic finishCycle();
    @(posedge clk);
    if (!clr && rf_if.ctrl_writeEnable && rf_if.ctrl_writeReg != 0)
      ref_regs[rf_if.ctrl_writeReg] = rf_if.data_writeReg;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
    clr                    = 1'b1;
    rf_if.ctrl_writeEnable = 1'b0;
    rf_if.ctrl_writeReg    = '0;
    rf_if.data_writeReg    = '0;
    rf_if.ctrl_readRegA    = '0;
    rf_if.ctrl_readRegB    = '0;
    repeat (2) @(posedge clk);

    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b0);
    checkOutput("reset_A", rf_if.data_readRegA, 32'h0);
    checkOutput("reset_B", rf_if.data_readRegB, 32'h0);
    finishCycle();

    // Directed table; no vector reads the register it is writing.
    table_v[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd6, 32'h0,        32'h0};
    table_v[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    table_v[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd6, 5'd5, 32'h0,        32'hDEADBEEF};
    table_v[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0};
    table_v[4] = '{1'b0, 5'd5, 32'h12345678, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
    table_v[5] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    table_v[6] = '{1'b1, 5'd3, 32'h0000A5A5, 5'd5, 5'd4, 32'hDEADBEEF, 32'h0};
    table_v[7] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 32'h0000A5A5, 32'h0};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(table_v[i].we, table_v[i].wa, table_v[i].wd,
                    table_v[i].ra, table_v[i].rb, 1'b0);
      checkOutput($sformatf("table%0d_A", i), rf_if.data_readRegA, table_v[i].exp_a);
      checkOutput($sformatf("table%0d_B", i), rf_if.data_readRegB, table_v[i].exp_b);
      finishCycle();
    end

    // Same-cycle read of the write target.
    applyStimulus(1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 1'b0);
    finishCycle();
    applyStimulus(1'b1, 5'd7, 32'h22, 5'd7, 5'd3, 1'b0);
    checkOutput("r7_same_cycle", rf_if.data_readRegA, BYPASS ? 32'h22 : 32'h11);
    finishCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0);
    checkOutput("r7_after_edge", rf_if.data_readRegA, 32'h22);
    finishCycle();

    // Mid-cycle clr pulse, no clock edge between assertion and check.
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd3, 1'b0);
    checkOutput("pre_clr_A", rf_if.data_readRegA, 32'hDEADBEEF);
    #1 clr = 1'b1;
    #1;
    checkOutput("async_clr_A", rf_if.data_readRegA, 32'h0);
    checkOutput("async_clr_B", rf_if.data_readRegB, 32'h0);
    for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
    finishCycle();
    for (int i = 0; i < NREG; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, ADDR_W'(i), ADDR_W'(NREG - 1 - i), 1'b1);
      checkOutput($sformatf("clr_sweep%0d_A", i), rf_if.data_readRegA, 32'h0);
      checkOutput($sformatf("clr_sweep%0d_B", i), rf_if.data_readRegB, 32'h0);
      finishCycle();
    end

    // clr held across a write edge, then released with the write still requested.
    applyStimulus(1'b1, 5'd9, 32'h55, 5'd9, 5'd9, 1'b1);
    checkOutput("clr_write_pre", rf_if.data_readRegA, 32'h0);
    finishCycle();
    applyStimulus(1'b1, 5'd9, 32'h55, 5'd0, 5'd0, 1'b0);
    checkOutput("clr_won_edge", dut.regs[9], 32'h0);
    finishCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0);
    checkOutput("r9_after_release", rf_if.data_readRegA, 32'h55);
    finishCycle();

    // Full sweep of distinct values, then paired reads with idle write data.
    for (int i = 1; i < NREG; i++) begin
      applyStimulus(1'b1, ADDR_W'(i), i * 32'h01010101, 5'd0, 5'd0, 1'b0);
      finishCycle();
    end
    for (int i = 0; i < NREG; i++) begin
      applyStimulus(1'b0, ADDR_W'($urandom_range(0, NREG - 1)), $urandom,
                    ADDR_W'(i), ADDR_W'(NREG - 1 - i), 1'b0);
      checkOutput($sformatf("sweep%0d_A", i), rf_if.data_readRegA, i * 32'h01010101);
      checkOutput($sformatf("sweep%0d_B", i), rf_if.data_readRegB,
                  (NREG - 1 - i) * 32'h01010101);
      finishCycle();
    end

    // Random traffic against the array model, with occasional collisions and clears.
    for (int n = 0; n < 600; n++) begin
      logic [ADDR_W-1:0] wa;
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W-1:0] rb;
      wa = ADDR_W'($urandom_range(0, NREG - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, NREG - 1));
      rb = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, NREG - 1));
      applyStimulus(($urandom_range(0, 3) != 0), wa, $urandom, ra, rb,
                    ($urandom_range(0, 49) == 0));
      checkModel($sformatf("rand%0d", n));
      finishCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
